// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard detection and forwarding-select block for the 5-stage pipeline.
//   A DEPTH-entry scoreboard shadows the instructions issued after ID
//   (entry 0 = EXE, entry DEPTH-1 = oldest). From the ID operands it derives:
//     freeze_out      - hold PC / IF-ID and bubble EXE (combinational)
//     flush_out       - kill IF-ID on a taken branch (combinational)
//     fwd_sel1/2_out  - 0 = register file, k = scoreboard entry k-1
//     stall_count_out - saturating count of freeze cycles since reset
//
//   Build option: define FORWARDING_EN to stall only on load-use and drive
//   the forwarding selects. Without it every RAW hit stalls until the writer
//   drains out of the scoreboard and the selects are tied to 0.
//
// Ports:
//   clk, rst (async, active high)
//   id_valid_in, src1_in, src2_in, two_src_in, id_wb_en_in, id_mem_read_in,
//   id_dest_in   - ID-stage instruction description
//   branch_taken_in - branch resolved taken in EXE
//   freeze_out, flush_out, fwd_sel1_out, fwd_sel2_out, stall_count_out

// Per-entry comparator: one instance per scoreboard entry.
module hazard_scoreboard_match #(
  parameter int REG_ADDR_W = 4
) (
  input  logic                  vld,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  two_src,
  output logic                  hit1,
  output logic                  hit2
);
  logic wr;
  assign wr   = vld & wb_en;
  assign hit1 = wr & (dest == src1);
  // src2 only counts when the instruction actually reads it
  assign hit2 = wr & two_src & (dest == src2);
endmodule

module hazard_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 3,
  parameter int CNT_W      = 16,
  parameter int FWD_W      = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_in,
  input  logic [REG_ADDR_W-1:0] src1_in,
  input  logic [REG_ADDR_W-1:0] src2_in,
  input  logic                  two_src_in,
  input  logic                  id_wb_en_in,
  input  logic                  id_mem_read_in,
  input  logic [REG_ADDR_W-1:0] id_dest_in,
  input  logic                  branch_taken_in,
  output logic                  freeze_out,
  output logic                  flush_out,
  output logic [FWD_W-1:0]      fwd_sel1_out,
  output logic [FWD_W-1:0]      fwd_sel2_out,
  output logic [CNT_W-1:0]      stall_count_out
);

  // Scoreboard state; vld_pipe_q is the valid shift register.
  logic [DEPTH-1:0]                 vld_pipe_q, vld_pipe_d;
  logic [DEPTH-1:0]                 wb_q, wb_d;
  logic [DEPTH-1:0]                 mr_q, mr_d;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] dest_q, dest_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;

  logic [DEPTH-1:0] hit1, hit2;
  logic             hazard;
  logic             freeze, flush;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      hazard_scoreboard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match (
        .vld     (vld_pipe_q[g]),
        .wb_en   (wb_q[g]),
        .dest    (dest_q[g]),
        .src1    (src1_in),
        .src2    (src2_in),
        .two_src (two_src_in),
        .hit1    (hit1[g]),
        .hit2    (hit2[g])
      );
    end
  endgenerate

`ifdef FORWARDING_EN
  logic [FWD_W-1:0] sel1, sel2;

  // Only a load sitting in EXE cannot be forwarded in time.
  assign hazard = id_valid_in & (hit1[0] | hit2[0]) & mr_q[0];

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (hit1[i]) sel1 = FWD_W'(i+1);
      if (hit2[i]) sel2 = FWD_W'(i+1);
    end
  end

  assign fwd_sel1_out = (id_valid_in && !rst) ? sel1 : '0;
  assign fwd_sel2_out = (id_valid_in && !rst) ? sel2 : '0;
`else
  // Without forwarding the load flag carries no information.
  logic unused_mr;
  assign unused_mr = ^mr_q;

  assign hazard       = id_valid_in & (|hit1 | |hit2);
  assign fwd_sel1_out = '0;
  assign fwd_sel2_out = '0;
`endif

  // Flush wins over freeze; both read 0 while reset is held.
  assign flush  = branch_taken_in & ~rst;
  assign freeze = hazard & ~branch_taken_in & ~rst;

  assign freeze_out      = freeze;
  assign flush_out       = flush;
  assign stall_count_out = cnt_q;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    wb_d       = wb_q;
    mr_d       = mr_q;
    dest_d     = dest_q;
    // Stages after ID never stall: the scoreboard shifts every cycle.
    for (int i = DEPTH-1; i >= 1; i--) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      wb_d[i]       = wb_q[i-1];
      mr_d[i]       = mr_q[i-1];
      dest_d[i]     = dest_q[i-1];
    end
    if (flush || freeze) begin
      vld_pipe_d[0] = 1'b0;
      wb_d[0]       = 1'b0;
      mr_d[0]       = 1'b0;
      dest_d[0]     = '0;
    end else begin
      vld_pipe_d[0] = id_valid_in;
      wb_d[0]       = id_wb_en_in;
      mr_d[0]       = id_mem_read_in;
      dest_d[0]     = id_dest_in;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (freeze && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      wb_q       <= '0;
      mr_q       <= '0;
      dest_q     <= '0;
      cnt_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      wb_q       <= wb_d;
      mr_q       <= mr_d;
      dest_q     <= dest_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection and forwarding-select block for the 5-stage ARM pipeline. It replaces the constant-zero freeze/flush ties at the top level. An internal scoreboard shadows the last DEPTH issued instructions (EXE..WB) and drives three outputs: freeze_out to the IF/ID stages, flush_out on taken branches, and per-source forwarding selects. A saturating stall counter supports performance analysis.

## Interface
- REG_ADDR_W, 4, register address width (matches REG_ADDRESS_LEN)
- DEPTH, 3, in-flight stages tracked after ID (entry 0 = EXE, entry DEPTH-1 = oldest); legal 1..7
- CNT_W, 16, stall-counter width
- FWD_W, $clog2(DEPTH+1), derived forwarding-select width; not overridden
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid_in  in  1  ID holds a real instruction
- src1_in  in  REG_ADDR_W  Rn address in ID
- src2_in  in  REG_ADDR_W  second-source address in ID
- two_src_in  in  1  src2_in is used
- id_wb_en_in  in  1  ID instruction writes a register
- id_mem_read_in  in  1  ID instruction is a load
- id_dest_in  in  REG_ADDR_W  ID destination
- branch_taken_in  in  1  branch resolved taken in EXE this cycle
- freeze_out  out  1  hold PC and IF/ID register, insert bubble into EXE
- flush_out  out  1  kill the instruction in IF/ID
- fwd_sel1_out  out  FWD_W  0 = register file, k = entry k-1
- fwd_sel2_out  out  FWD_W  same, for src2
- stall_count_out  out  CNT_W  total freeze cycles since reset, saturating

## Operation
- Scoreboard entry fields: {valid, wb_en, mem_read, dest}. Every clock, entry[i] <= entry[i-1] for i >= 1. The scoreboard never stalls: stages after ID never freeze.
- Entry 0 load: bubble (valid=0) if flush_out or freeze_out is high. Otherwise it loads {id_valid_in, id_wb_en_in, id_mem_read_in, id_dest_in}.
- Entry match: valid & wb_en & dest == src. src2 is considered only when two_src_in=1. A match on src1 or src2 is a source hit.
- freeze_out, forwarding build (macro below) is combinational. It is high when id_valid_in & !branch_taken_in & entry 0 matches with mem_read=1 (load-use).
- freeze_out, non-forwarding build is combinational. It is high when id_valid_in & !branch_taken_in & any entry matches.
- flush_out = branch_taken_in, combinational. Flush has priority over freeze.
- fwd_selN_out is the youngest matching entry index + 1, else 0. It is forced to 0 when src N is unused, when id_valid_in=0, or when the macro is absent.
- stall_count_out increments on each clock where freeze_out=1 and holds at 2^CNT_W-1.

## Timing
- freeze_out, flush_out and fwd_sel are combinational from the inputs and scoreboard state, with zero latency. The scoreboard updates at the rising edge.
- A load-use hazard stalls exactly 1 cycle. In the non-forwarding build, a hit on entry k stalls DEPTH-k cycles.
- Simultaneous branch_taken_in and hazard: flush_out=1, freeze_out=0, entry 0 gets a bubble, and the counter does not increment.
- Source equal to several entries: the youngest (lowest index) wins.
- Reset, including mid-stall: all entries invalid and counter 0. freeze_out, flush_out and fwd_sel read 0 while rst is high. The first post-reset instruction sees no hazard.
- DEPTH=1: only EXE is tracked. fwd_sel is 1 bit.

## Configuration
- FORWARDING_EN defined: load-use-only stalls, and fwd_sel outputs are active.
- FORWARDING_EN undefined: any RAW hit stalls until the writer leaves the scoreboard, and fwd_sel outputs are constant 0.

## Test plan
- Reset applied mid-stall (entry 0 = load to R3, ID reads R3) -> freeze_out drops to 0 asynchronously; stall_count_out=0 after release.
- FORWARDING_EN, ADD R1 then SUB reads R1 -> freeze_out=0, fwd_sel1_out=1. The next cycle, an unrelated instruction reading R1 gets fwd_sel1_out=2.
- FORWARDING_EN, LDR R2 then ADD reads R2 as src2 with two_src_in=1 -> freeze_out=1 for 1 cycle, then fwd_sel2_out=2; stall_count_out=1.
- No macro, DEPTH=3, ADD R5 then reader of R5 -> freeze_out high for 3 cycles, then 0; stall_count_out=3; fwd_sel always 0.
- branch_taken_in=1 while ID has a load-use hazard -> flush_out=1, freeze_out=0, entry 0 bubble; the next cycle shows no stale hit.
- CNT_W=2, 5 consecutive stalls -> stall_count_out reads 1,2,3,3,3.
